// File: rtl/spi2adc_pkg.sv
// spi_adc_pkg: shared FSM states, frame geometry and command bits for the MCP3002 reader
package spi_adc_pkg;
    typedef enum logic [1:0] {IDLE, CS_SETUP, SHIFT, CS_HOLD} state_t;
    localparam int FRAME_BITS = 16;
    localparam logic [4:0] LAST_BIT_IDX = 5'(FRAME_BITS - 1);
    localparam logic [4:0] NULL_BIT_IDX = 5'd5;
    localparam logic [4:0] FIRST_DATA_IDX = NULL_BIT_IDX + 5'd1;
    localparam logic START = 1'b1;
    localparam logic SGL = 1'b1;
    localparam logic MSBF = 1'b1;
    // Din bit for 0-based frame bit idx: leading alignment zero, then start/sgl/odd/msbf, then zeros
    function automatic logic cmd_bit(input logic [4:0] idx, input logic ch);
        return idx == 5'd1 ? START : idx == 5'd2 ? SGL : idx == 5'd3 ? ch : idx == 5'd4 ? MSBF : 1'b0;
    endfunction
endpackage

// File: rtl/spi2adc_if.sv
// spi2adc_if: ADC pins plus request/result signals of the SPI ADC reader
interface spi2adc_if;
    logic start, channel, adc_sdo, adc_cs, adc_sck, adc_sdi, data_valid, busy;
    logic [9:0] data_out;
    modport master (input start, channel, adc_sdo, output adc_cs, adc_sck, adc_sdi, data_out, data_valid, busy);
    modport slave (output start, channel, adc_sdo, input adc_cs, adc_sck, adc_sdi, data_out, data_valid, busy);
endinterface

// File: rtl/spi2adc_sck_gen.sv
// spi_sck_gen: half-period counter and SCK toggler; pulses mark the sysclk edge where SCK changes
module spi_sck_gen #(parameter int unsigned HALF_PERIOD = 25) (
    input  logic sysclk,
    input  logic reset,
    input  logic en,
    input  logic toggle,
    output logic sck,
    output logic rise_pulse,
    output logic fall_pulse,
    output logic period_done
);
    logic [7:0] cnt;
    assign period_done = en && cnt == 8'(HALF_PERIOD - 1);
    assign rise_pulse = toggle && period_done && !sck;
    assign fall_pulse = toggle && period_done && sck;
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            cnt <= 8'd0;
            sck <= 1'b0;
        end else begin
            cnt <= (!en || period_done) ? 8'd0 : cnt + 8'd1;
            sck <= toggle && (sck ^ period_done);
        end
    end
endmodule

// File: rtl/spi2adc.sv
// spi2adc: SPI master reading one 10-bit MCP3002 conversion per accepted start strobe
module spi2adc
    import spi_adc_pkg::*;
#(
    parameter int unsigned HALF_PERIOD = 25
) (
    input logic sysclk,
    input logic reset,
    spi2adc_if.master bus
);
    state_t state, nxt;
    logic ch, rise, fall, pd, last_fall, cs_d, busy_d;
    logic [4:0] bc;
    logic [9:0] shreg;
    spi_sck_gen #(.HALF_PERIOD(HALF_PERIOD)) u_sck (
        .sysclk(sysclk),
        .reset(reset),
        .en(state != IDLE),
        .toggle(state == SHIFT),
        .sck(bus.adc_sck),
        .rise_pulse(rise),
        .fall_pulse(fall),
        .period_done(pd)
    );
    assign last_fall = fall && bc == LAST_BIT_IDX;
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) state <= IDLE;
        else state <= nxt;
    end
    // A start present when CS_HOLD expires chains straight into the next frame
    always_comb begin
        nxt = state;
        case (state)
            IDLE:     nxt = bus.start ? CS_SETUP : IDLE;
            CS_SETUP: nxt = pd ? SHIFT : CS_SETUP;
            SHIFT:    nxt = last_fall ? CS_HOLD : SHIFT;
            CS_HOLD:  nxt = pd ? (bus.start ? CS_SETUP : IDLE) : CS_HOLD;
            default:  nxt = IDLE;
        endcase
    end
    always_comb begin
        cs_d = !(nxt == CS_SETUP || nxt == SHIFT);
        busy_d = nxt != IDLE;
    end
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            bus.adc_cs <= 1'b1;
            bus.busy <= 1'b0;
            bus.adc_sdi <= 1'b0;
            bus.data_out <= 10'd0;
            bus.data_valid <= 1'b0;
            ch <= 1'b0;
            bc <= 5'd0;
            shreg <= 10'd0;
        end else begin
            bus.adc_cs <= cs_d;
            bus.busy <= busy_d;
            bus.data_valid <= last_fall;
            if (nxt == CS_SETUP && state != CS_SETUP) ch <= bus.channel;
            if (last_fall) bus.data_out <= shreg;
            bc <= (state != SHIFT || last_fall) ? 5'd0 : bc + 5'(fall);
            if (rise && bc >= FIRST_DATA_IDX) shreg <= {shreg[8:0], bus.adc_sdo};
            bus.adc_sdi <= (state == CS_SETUP && pd) ? cmd_bit(5'd0, ch)
                         : (fall && !last_fall) ? cmd_bit(bc + 5'd1, ch)
                         : (state == SHIFT && !last_fall) ? bus.adc_sdi : 1'b0;
        end
    end
endmodule

// File: tb/tb_spi2adc.sv
// tb_spi2adc: scoreboard bench with behavioural MCP3002 models for HALF_PERIOD 25 and 2 builds
module tb_spi2adc;
    typedef struct {logic [9:0] data; logic ch; int cyc;} exp_t;
    logic sysclk = 1'b0, reset = 1'b1, prev;
    int cyc = 0, checks = 0, passes = 0, acc, t1, t2, nr, r0, r1, rc1, rc2;
    exp_t exp1[$], exp2[$];
    logic [9:0] resp1[$], resp2[$];
    logic [9:0] tv[3] = '{10'h001, 10'h200, 10'h2AA};
    logic [15:0] pat1, pat2, rx1, rx2;
    spi2adc_if b1();
    spi2adc_if b2();
    spi2adc #(.HALF_PERIOD(25)) u1 (.sysclk(sysclk), .reset(reset), .bus(b1));
    spi2adc #(.HALF_PERIOD(2)) u2 (.sysclk(sysclk), .reset(reset), .bus(b2));
    always #5 sysclk = ~sysclk;
    always @(posedge sysclk) cyc <= cyc + 1;
    // ADC models: prefix and null bit are driven 1 so mis-aligned sampling corrupts the data
    always @(negedge b1.adc_cs) begin
        pat1 = {6'h3F, 10'h155};
        if (resp1.size() > 0) pat1[9:0] = resp1.pop_front();
        rc1 = 0;
        b1.adc_sdo = pat1[15];
    end
    always @(posedge b1.adc_sck) begin
        rc1++;
        rx1 = {rx1[14:0], b1.adc_sdi};
    end
    always @(negedge b1.adc_sck) if (rc1 < 16) b1.adc_sdo = pat1[15 - rc1];
    always @(negedge b2.adc_cs) begin
        pat2 = {6'h3F, 10'h155};
        if (resp2.size() > 0) pat2[9:0] = resp2.pop_front();
        rc2 = 0;
        b2.adc_sdo = pat2[15];
    end
    always @(posedge b2.adc_sck) begin
        rc2++;
        rx2 = {rx2[14:0], b2.adc_sdi};
    end
    always @(negedge b2.adc_sck) if (rc2 < 16) b2.adc_sdo = pat2[15 - rc2];

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act == req) passes++;
        else $display("FAIL %s: got %0h, required %0h", nm, act, req);
    endtask

    task automatic score(input int i, input logic [9:0] d, input logic [15:0] rx, input int rc);
        exp_t e;
        if ((i == 0 ? exp1.size() : exp2.size()) == 0) begin
            checks++;
            $display("FAIL unexpected_valid dut%0d: got data %h, required no valid", i, d);
            return;
        end
        if (i == 0) e = exp1.pop_front();
        else e = exp2.pop_front();
        chk($sformatf("dut%0d_data", i), d, e.data);
        chk($sformatf("dut%0d_valid_cycle", i), cyc, e.cyc);
        chk($sformatf("dut%0d_cmd_bits", i), rx[15:11], {1'b0, 1'b1, 1'b1, e.ch, 1'b1});
        chk($sformatf("dut%0d_sdi_tail", i), rx[10:0], 0);
        chk($sformatf("dut%0d_sck_rises", i), rc, 16);
    endtask

    always @(negedge sysclk) begin
        if (b1.data_valid) score(0, b1.data_out, rx1, rc1);
        if (b2.data_valid) score(1, b2.data_out, rx2, rc2);
    end

    task automatic go1(input logic ch, input logic [9:0] d);
        acc = cyc + 1;
        b1.channel = ch;
        b1.start = 1'b1;
        resp1.push_back(d);
        exp1.push_back('{d, ch, acc + 825});
        @(negedge sysclk);
        b1.start = 1'b0;
    endtask

    task automatic wait_busy1(input int req);
        for (int n = 0; n < 3000 && b1.busy; n++) @(negedge sysclk);
        chk("busy_end_cycle", cyc, req);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        b1.start = 0; b1.channel = 0; b1.adc_sdo = 0;
        b2.start = 0; b2.channel = 0; b2.adc_sdo = 0;
        repeat (3) @(negedge sysclk);
        chk("rst_cs", b1.adc_cs, 1);
        chk("rst_sck", b1.adc_sck, 0);
        chk("rst_sdi", b1.adc_sdi, 0);
        chk("rst_data", b1.data_out, 0);
        chk("rst_valid", b1.data_valid, 0);
        chk("rst_busy", b1.busy, 0);
        reset = 0;
        @(negedge sysclk);
        // HALF_PERIOD=2 build: 4-cycle SCK, 16 rises, latency 66, busy 68
        acc = cyc + 1;
        b2.channel = 1;
        b2.start = 1;
        resp2.push_back(10'h0CA);
        exp2.push_back('{10'h0CA, 1'b1, acc + 66});
        @(negedge sysclk);
        b2.start = 0;
        prev = 0; nr = 0; r0 = 0; r1 = 0;
        for (int n = 0; n < 200 && b2.busy; n++) begin
            if (b2.adc_sck && !prev) begin
                if (nr == 0) r0 = cyc;
                else if (nr == 1) r1 = cyc;
                nr++;
            end
            prev = b2.adc_sck;
            @(negedge sysclk);
        end
        chk("hp2_busy_end", cyc, acc + 68);
        chk("hp2_first_rise", r0, acc + 4);
        chk("hp2_sck_period", r1 - r0, 4);
        chk("hp2_rise_count", nr, 16);
        // single conversion, CH0
        go1(0, 10'h2A5);
        chk("busy_on_accept", b1.busy, 1);
        chk("cs_on_accept", b1.adc_cs, 0);
        wait_busy1(acc + 850);
        // start held high, CH1, channel toggled mid-frame during the command bits
        acc = cyc + 1;
        b1.channel = 1;
        b1.start = 1;
        resp1.push_back(10'h3FF);
        resp1.push_back(10'h000);
        exp1.push_back('{10'h3FF, 1'b1, acc + 825});
        exp1.push_back('{10'h000, 1'b1, acc + 1675});
        repeat (100) @(negedge sysclk);
        b1.channel = 0;
        repeat (300) @(negedge sysclk);
        b1.channel = 1;
        for (int n = 0; n < 1000 && !b1.adc_cs; n++) @(negedge sysclk);
        t1 = cyc;
        for (int n = 0; n < 100 && b1.adc_cs; n++) @(negedge sysclk);
        t2 = cyc;
        chk("cs_high_between", t2 - t1, 25);
        chk("cs_rise_cycle", t1, acc + 825);
        b1.start = 0;
        wait_busy1(acc + 1700);
        // extra start mid-frame is ignored
        go1(0, 10'h15A);
        repeat (299) @(negedge sysclk);
        b1.start = 1;
        @(negedge sysclk);
        b1.start = 0;
        wait_busy1(acc + 850);
        repeat (5) @(negedge sysclk);
        chk("idle_after_ignored", b1.busy, 0);
        // reset mid-frame while SCK is high
        acc = cyc + 1;
        resp1.push_back(10'h123);
        b1.channel = 0;
        b1.start = 1;
        @(negedge sysclk);
        b1.start = 0;
        repeat (400) @(negedge sysclk);
        chk("sck_high_before_reset", b1.adc_sck, 1);
        reset = 1;
        #1;
        chk("abort_cs", b1.adc_cs, 1);
        chk("abort_sck", b1.adc_sck, 0);
        chk("abort_busy", b1.busy, 0);
        chk("abort_data", b1.data_out, 0);
        repeat (3) @(negedge sysclk);
        reset = 0;
        repeat (20) @(negedge sysclk);
        chk("data_after_abort", b1.data_out, 0);
        go1(1, 10'h0F0);
        wait_busy1(acc + 850);
        // clk_tick-paced starts every 5000 cycles
        for (int k = 0; k < 3; k++) begin
            chk("busy_at_tick", b1.busy, 0);
            go1(k[0], tv[k]);
            repeat (4999) @(negedge sysclk);
        end
        chk("tick_data_held", b1.data_out, 10'h2AA);
        chk("exp1_pending", exp1.size(), 0);
        chk("exp2_pending", exp2.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
